// File: rtl/mm_seq_pkg.sv
// Shared types and constants for the matrix-multiplier host sequencer.
package mm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD_IM,
        S_LOAD_DM,
        S_RUN,
        S_RD,
        S_RD_WAIT,
        S_TX
    } state_e;

    localparam int unsigned HDR_BYTES    = 7;
    localparam int unsigned OFF_IM_LEN   = 0;
    localparam int unsigned OFF_DM_LEN   = 1;
    localparam int unsigned OFF_RES_BASE = 3;
    localparam int unsigned OFF_RES_LEN  = 5;

    // im_len of zero encodes a full 256-word program.
    function automatic logic [15:0] im_words(input logic [7:0] len);
        return (len == 8'd0) ? 16'd256 : {8'd0, len};
    endfunction

endpackage

// File: rtl/mm_seq_hdr.sv
// Header capture: collects the 7 big-endian header bytes into the job field registers.
module mm_seq_hdr
    import mm_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  hdr_byte,
    input  logic        hdr_valid,
    input  logic        hdr_clear,
    output logic [7:0]  im_len,
    output logic [15:0] dm_len,
    output logic [15:0] res_base,
    output logic [15:0] res_len,
    output logic        hdr_done
);

    logic [2:0]                  cnt_q, cnt_d;
    logic [HDR_BYTES-1:0][7:0]   bytes_q, bytes_d;

    always_comb begin
        cnt_d    = cnt_q;
        bytes_d  = bytes_q;
        hdr_done = 1'b0;
        if (hdr_clear) begin
            cnt_d   = '0;
            bytes_d = '0;
        end else if (hdr_valid) begin
            bytes_d[cnt_q] = hdr_byte;
            if (cnt_q == 3'(HDR_BYTES - 1)) begin
                cnt_d    = '0;
                hdr_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bytes_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
        end
    end

    assign im_len   = bytes_q[OFF_IM_LEN];
    assign dm_len   = {bytes_q[OFF_DM_LEN],   bytes_q[OFF_DM_LEN + 1]};
    assign res_base = {bytes_q[OFF_RES_BASE], bytes_q[OFF_RES_BASE + 1]};
    assign res_len  = {bytes_q[OFF_RES_LEN],  bytes_q[OFF_RES_LEN + 1]};

endmodule

// File: rtl/mm_host_sequencer.sv
// Host run controller: loads IM/DM from the host byte stream, runs the core, streams results back.
// Optional run watchdog enabled by defining RUN_TIMEOUT_EN.
module mm_host_sequencer
    import mm_seq_pkg::*;
#(
    parameter int unsigned IM_AW       = 8,
    parameter int unsigned DM_AW       = 12,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             im_wr,
    output logic [IM_AW-1:0] im_addr,
    output logic [7:0]       im_wdata,
    output logic             dm_wr,
    output logic [DM_AW-1:0] dm_addr,
    output logic [7:0]       dm_wdata,
    input  logic [7:0]       dm_rdata,
    output logic             core_rst_n,
    input  logic             end_op,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        hdr_clear;
`ifdef RUN_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
`endif

    logic [7:0]  im_len;
    logic [15:0] dm_len, res_base, res_len;
    logic        hdr_done;

    mm_seq_hdr u_hdr (
        .clk       (clk),
        .rst_n     (rst_n),
        .hdr_byte  (rx_data),
        .hdr_valid (rx_valid && (state_q == S_HDR)),
        .hdr_clear (hdr_clear),
        .im_len    (im_len),
        .dm_len    (dm_len),
        .res_base  (res_base),
        .res_len   (res_len),
        .hdr_done  (hdr_done)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = err_q;
        done_d     = 1'b0;
        hdr_clear  = 1'b0;
`ifdef RUN_TIMEOUT_EN
        wd_d = (state_q == S_RUN) ? wd_q + 32'd1 : '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    hdr_clear = 1'b1;
                end
            end
            S_HDR: begin
                if (hdr_done) state_d = S_LOAD_IM;
            end
            S_LOAD_IM: begin
                if (rx_valid) begin
                    if (cnt_q + 16'd1 == im_words(im_len)) begin
                        cnt_d   = '0;
                        state_d = (dm_len != 16'd0) ? S_LOAD_DM : S_RUN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_LOAD_DM: begin
                if (rx_valid) begin
                    if (cnt_q + 16'd1 == dm_len) begin
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_RUN: begin
                if (end_op) begin
                    state_d = (res_len != 16'd0) ? S_RD : S_IDLE;
                    done_d  = (res_len == 16'd0);
                end
`ifdef RUN_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_RD: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // dm_rdata now reflects the address presented during S_RD
                tx_data_d  = dm_rdata;
                tx_valid_d = 1'b1;
                state_d    = S_TX;
            end
            S_TX: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    idx_d      = idx_q + 16'd1;
                    if (idx_q + 16'd1 == res_len) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        core_rst_n_d = (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef RUN_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef RUN_TIMEOUT_EN
            wd_q         <= wd_d;
`endif
        end
    end

    // Load strobes follow rx_valid in the same cycle, so they are decoded from state.
    assign im_wr    = (state_q == S_LOAD_IM) && rx_valid;
    assign im_addr  = IM_AW'(cnt_q);
    assign im_wdata = im_wr ? rx_data : '0;
    assign dm_wr    = (state_q == S_LOAD_DM) && rx_valid;
    assign dm_wdata = dm_wr ? rx_data : '0;

    always_comb begin
        dm_addr = '0;
        if (state_q == S_LOAD_DM)
            dm_addr = DM_AW'(cnt_q);
        else if ((state_q == S_RD) || (state_q == S_RD_WAIT))
            dm_addr = DM_AW'(res_base + idx_q);
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Self-checking bench for mm_host_sequencer against a job-level reference model.
module tb_mm_host_sequencer;

    localparam int unsigned IM_AW = 8;
    localparam int unsigned DM_AW = 12;
`ifdef RUN_TIMEOUT_EN
    localparam int unsigned TB_TO = 50;
`else
    localparam int unsigned TB_TO = 1000000;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             im_wr;
    logic [IM_AW-1:0] im_addr;
    logic [7:0]       im_wdata;
    logic             dm_wr;
    logic [DM_AW-1:0] dm_addr;
    logic [7:0]       dm_wdata;
    logic [7:0]       dm_rdata;
    logic             core_rst_n;
    logic             end_op;
    logic             busy;
    logic             done;
    logic             err;

    mm_host_sequencer #(.IM_AW(IM_AW), .DM_AW(DM_AW), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .im_wr(im_wr), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .core_rst_n(core_rst_n), .end_op(end_op), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Data memory with one-cycle read latency plus a preload port for the bench.
    logic [7:0]  mem [4096] = '{default: 8'h00};
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    always @(posedge clk) begin
        if (dm_wr) mem[dm_addr] <= dm_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
        dm_rdata <= mem[dm_addr];
    end

    logic [15:0] im_q [$];
    logic [19:0] dm_q [$];
    logic [7:0]  tx_q [$];
    int          done_cnt = 0, both_cnt = 0, unstable_cnt = 0;
    logic        prev_v = 1'b0, prev_hs = 1'b0;
    logic [7:0]  prev_d = '0;
    always @(negedge clk) begin
        if (im_wr) im_q.push_back({im_addr, im_wdata});
        if (dm_wr) dm_q.push_back({dm_addr, dm_wdata});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (done) done_cnt++;
        if (im_wr && dm_wr) both_cnt++;
        if (prev_v && !prev_hs && (!tx_valid || tx_data != prev_d)) unstable_cnt++;
        prev_v  = tx_valid;
        prev_d  = tx_data;
        prev_hs = tx_valid && tx_ready;
    end

    int rdy_mode = 0;
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    int         checks = 0, errors = 0;
    logic [7:0] ref_mem [4096];
    logic [7:0] im_b [256];
    logic [7:0] dm_b [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) step();
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic logic [50:0] all_outs();
        return {tx_data, tx_valid, im_wr, im_addr, im_wdata, dm_wr, dm_addr, dm_wdata,
                core_rst_n, busy, done, err};
    endfunction

    task automatic run_job(input logic [7:0] iml, input logic [15:0] dml, input logic [15:0] rb,
                           input logic [15:0] rl, input int rdy, input bit stall, input bit xstart,
                           input int run_wait, input bit skip_start);
        int         n_im, total, k, b_im, b_dm, b_tx, b_done;
        logic [7:0] hdr [7];
        logic [7:0] exp_tx [$];
        n_im   = (iml == 8'd0) ? 256 : int'(iml);
        total  = n_im + int'(dml);
        b_im   = im_q.size();
        b_dm   = dm_q.size();
        b_tx   = tx_q.size();
        b_done = done_cnt;
        for (int i = 0; i < int'(dml); i++) ref_mem[i % 4096] = dm_b[i];
        for (int i = 0; i < int'(rl); i++) exp_tx.push_back(ref_mem[(int'(rb) + i) % 4096]);
        rdy_mode = stall ? 2 : rdy;
        if (!skip_start) begin
            start = 1'b1; step(); start = 1'b0;
        end
        hdr = '{iml, dml[15:8], dml[7:0], rb[15:8], rb[7:0], rl[15:8], rl[7:0]};
        for (int i = 0; i < 7; i++) begin
            if (xstart && i == 2) start = 1'b1;
            send_byte(hdr[i]);
            start = 1'b0;
        end
        for (int i = 0; i < total; i++) begin
            if (i == total - 1) chk("core_held_in_load", 64'(core_rst_n), 0);
            send_byte(i < n_im ? im_b[i] : dm_b[i - n_im]);
        end
        chk("core_release", 64'(core_rst_n), 1);
        send_byte(8'($urandom));
        repeat (run_wait) step();
        chk("run_status", 64'({busy, core_rst_n, err}), 64'(3'b110));
        end_op = 1'b1; step(); end_op = 1'b0;
        chk("core_reset_after_end", 64'(core_rst_n), 0);
        if (stall && rl != 16'd0) begin
            k = 0;
            while (tx_valid !== 1'b1 && k < 20) begin step(); k++; end
            chk("stall_tx_seen", 64'(tx_valid), 1);
            repeat (5) begin
                step();
                chk("stall_hold", 64'({tx_valid, tx_data}), 64'({1'b1, exp_tx[0]}));
            end
            rdy_mode = 0;
        end
        k = 0;
        while (busy !== 1'b0 && k < 5000) begin step(); k++; end
        chk("job_finished", 64'(busy), 0);
        step();
        chk("done_once", 64'(done_cnt - b_done), 1);
        chk("idle_outputs", 64'({core_rst_n, err, tx_valid, done}), 0);
        chk("im_count", 64'(im_q.size() - b_im), 64'(n_im));
        for (int i = 0; i < n_im && b_im + i < im_q.size(); i++)
            chk("im_write", 64'(im_q[b_im + i]), 64'({8'(i), im_b[i]}));
        chk("dm_count", 64'(dm_q.size() - b_dm), 64'(dml));
        for (int i = 0; i < int'(dml) && b_dm + i < dm_q.size(); i++)
            chk("dm_write", 64'(dm_q[b_dm + i]), 64'({12'(i), dm_b[i]}));
        chk("tx_count", 64'(tx_q.size() - b_tx), 64'(rl));
        for (int i = 0; i < int'(rl) && b_tx + i < tx_q.size(); i++)
            chk("tx_byte", 64'(tx_q[b_tx + i]), 64'(exp_tx[i]));
        chk("single_strobe", 64'(both_cnt), 0);
        chk("tx_stable", 64'(unstable_cnt), 0);
    endtask

    initial begin
        int k, b_tx, b_done;
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0; end_op = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(all_outs()), 0);
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", 64'(all_outs()), 0);

        send_byte(8'h55);
        chk("idle_rx_dropped", 64'(im_q.size() + dm_q.size()), 0);

        // Job 1: basic load, run and two-byte readback
        poke(12'h010, 8'h2A);
        poke(12'h011, 8'h2B);
        im_b[0] = 8'hA1; im_b[1] = 8'hA2;
        dm_b[0] = 8'h05; dm_b[1] = 8'h06; dm_b[2] = 8'h07;
        run_job(8'd2, 16'd3, 16'h0010, 16'd2, 0, 1'b0, 1'b0, 0, 1'b0);

        // Job 2: no DM load, no readback
        for (int i = 0; i < 3; i++) im_b[i] = 8'($urandom);
        run_job(8'd3, 16'd0, 16'h1234, 16'd0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Job 3: readback wraps across the top of DM
        poke(12'hFFF, 8'h5A);
        poke(12'h000, 8'hC3);
        im_b[0] = 8'($urandom);
        run_job(8'd1, 16'd0, 16'h0FFF, 16'd2, 0, 1'b0, 1'b0, 0, 1'b0);

        // Job 4: host stalls tx_ready mid-readback
        for (int i = 0; i < 4; i++) im_b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) dm_b[i] = 8'($urandom);
        run_job(8'd4, 16'd5, 16'h0000, 16'd4, 0, 1'b1, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of the DM load
        b_tx = tx_q.size(); b_done = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        send_byte(8'd1); send_byte(8'd0); send_byte(8'd10);
        send_byte(8'd0); send_byte(8'd0); send_byte(8'd0); send_byte(8'd1);
        send_byte(8'hEE);
        for (int i = 0; i < 3; i++) begin
            dm_b[i] = 8'($urandom);
            ref_mem[i] = dm_b[i];
            send_byte(dm_b[i]);
        end
        rx_valid = 1'b1; rx_data = 8'h99;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(all_outs()), 0);
        rx_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("abort_no_tx_no_done", 64'({tx_q.size() - b_tx, done_cnt - b_done}), 0);

        // Randomised jobs, with stray starts during the header and random host backpressure
        for (int r = 0; r < 4; r++) begin
            logic [7:0]  iml;
            logic [15:0] dml, rb, rl;
            iml = (r == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            dml = 16'($urandom_range(1, 40));
            rb  = {4'($urandom), (r == 1) ? 12'hFFC : 12'($urandom_range(0, int'(dml)))};
            rl  = 16'($urandom_range(1, 8));
            for (int i = 0; i < 256; i++) im_b[i] = 8'($urandom);
            for (int i = 0; i < 64; i++) dm_b[i] = 8'($urandom);
            run_job(iml, dml, rb, rl, 1, 1'b0, 1'b1, int'($urandom_range(0, 5)), 1'b0);
        end

`ifdef RUN_TIMEOUT_EN
        // Watchdog expiry: no end_op ever arrives
        b_tx = tx_q.size(); b_done = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        send_byte(8'd1); send_byte(8'd0); send_byte(8'd0);
        send_byte(8'd0); send_byte(8'd0); send_byte(8'd0); send_byte(8'd1);
        send_byte(8'h3C);
        chk("wd_core_release", 64'(core_rst_n), 1);
        k = 0;
        while (done !== 1'b1 && k < 200) begin step(); k++; end
        chk("wd_cycles", 64'(k), 50);
        chk("wd_flags", 64'({err, core_rst_n, busy}), 64'(3'b100));
        chk("wd_no_tx_one_done", 64'({tx_q.size() - b_tx, done_cnt - b_done}), 64'({32'd0, 32'd1}));
        start = 1'b1; step(); start = 1'b0;
        chk("wd_err_cleared", 64'(err), 0);
        im_b[0] = 8'($urandom);
        run_job(8'd1, 16'd0, 16'h0010, 16'd1, 0, 1'b0, 1'b0, 0, 1'b1);
`else
        // Without the watchdog a long run must not time out
        im_b[0] = 8'($urandom); im_b[1] = 8'($urandom);
        run_job(8'd2, 16'd0, 16'h0011, 16'd1, 0, 1'b0, 1'b0, 60, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_host_sequencer.md
Name: mm_host_sequencer

Overview:
- Top-level run controller for the single-core matrix multiplier.
- Receives a byte stream from the host link and loads instruction memory (IM) and data memory (DM).
- Releases the processor core from reset, waits for the core's end_op, then streams the result region of DM back to the host.
- Sits between the host byte interface (rx/tx) and the IM/DM write/read ports plus the core reset.

Parameters:
- IM_AW, 8, IM address width; IM depth is 2^IM_AW.
- DM_AW, 12, DM address width; DM depth is 2^DM_AW.
- TIMEOUT_CYC, 1000000, run watchdog limit in clk cycles; used only with RUN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- rx_data  in  8  host byte.
- rx_valid  in  1  rx_data valid for one cycle; no backpressure.
- tx_data  out  8  result byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts tx_data when tx_valid && tx_ready.
- im_wr  out  1  IM write strobe.
- im_addr  out  IM_AW  IM write address.
- im_wdata  out  8  IM write data.
- dm_wr  out  1  DM write strobe.
- dm_addr  out  DM_AW  DM address, shared by read and write.
- dm_wdata  out  8  DM write data.
- dm_rdata  in  8  DM read data, valid one cycle after dm_addr is presented.
- core_rst_n  out  1  core reset; 0 holds the core in reset.
- end_op  in  1  core finished; level or pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on entry to IDLE from a job.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0; core_rst_n=0; state IDLE. An asynchronous reset in any state aborts the job immediately, with no partial tx.
- Header: 7 bytes, big-endian: im_len[7:0], dm_len[15:0], res_base[15:0], res_len[15:0].
  - im_len=0 means 256 words.
  - Address fields are truncated to DM_AW.
- IDLE: start -> HDR; clear err and all counters.
- HDR: capture each rx_valid byte. After the 7th byte -> LOAD_IM.
- LOAD_IM:
  - Each rx_valid gives im_wr=1 in the same cycle, with im_wdata=rx_data and im_addr=counter from 0.
  - After im_len words: -> LOAD_DM if dm_len!=0, otherwise -> RUN.
- LOAD_DM: same scheme on the DM port from address 0 for dm_len bytes; the address wraps modulo 2^DM_AW.
- RUN:
  - core_rst_n=1 from the first RUN cycle.
  - end_op sampled high -> core_rst_n=0 next cycle; then -> RD if res_len!=0, else -> IDLE with done.
  - end_op is ignored in all other states because the core is held in reset.
- RD: drive dm_addr=res_base+idx (wraps) -> RD_WAIT (1 cycle) -> TX with tx_data=dm_rdata registered.
- TX:
  - Hold tx_valid=1 and stable tx_data until tx_ready.
  - On handshake, idx++. If idx==res_len -> IDLE and pulse done; otherwise -> RD.
  - Throughput is one byte per 3 cycles when tx_ready is tied high.
- rx_valid outside HDR/LOAD_* is dropped. start while busy is ignored.
- Only one of im_wr or dm_wr is ever high, and only in LOAD_* states.
- Counters are 16-bit; compare on the full 16 bits before address truncation.

Optional Feature:
- Macro RUN_TIMEOUT_EN.
- Defined:
  - A watchdog counts RUN cycles.
  - Reaching TIMEOUT_CYC without end_op sets err=1, drives core_rst_n=0, skips readback, and enters IDLE with done pulsed.
- Undefined: no watchdog; RUN waits indefinitely and err is never set.

Decomposition:
- Package mm_seq_pkg: state encoding (IDLE, HDR, LOAD_IM, LOAD_DM, RUN, RD, RD_WAIT, TX), HDR_BYTES=7, header field byte offsets.
- Sub-module mm_seq_hdr: header byte capture and field register file.
  - Inputs: byte, valid, clear.
  - Outputs: im_len, dm_len, res_base, res_len, hdr_done.
- FSM, counters and readback stay in mm_host_sequencer.

Test Plan:
- Header 02 0003 0010 0002, then IM bytes A1 A2 and DM bytes 05 06 07 -> im_wr at addresses 0,1 (A1,A2); dm_wr at 0,1,2 (05,06,07); core_rst_n rises after the last DM byte.
- Pulse end_op with DM model [0x10]=0x2A, [0x11]=0x2B and tx_ready=1 -> tx bytes 2A, 2B; done pulses once; busy falls; core_rst_n=0.
- Hold tx_ready=0 for 5 cycles mid-readback -> tx_valid stays 1 and tx_data stays stable; no byte lost or duplicated.
- Header with dm_len=0, res_len=0 -> no dm_wr; RUN follows LOAD_IM directly; end_op -> IDLE with done and no tx.
- res_base=0x0FFF, res_len=2 with DM_AW=12 -> reads addresses 0xFFF then 0x000.
- RUN_TIMEOUT_EN with TIMEOUT_CYC=50 and no end_op -> err=1 and done at cycle 50 of RUN; a new start clears err. Separately, rst_n=0 asserted mid-LOAD_DM -> all outputs 0 asynchronously.
